// File: rtl/task_result_packer.sv
// ---------------------------------------------------------------------------
// task_result_packer
//
// Sits between a task core and the shared-memory write master. Result samples
// arrive on a valid/ready stream and are packed little-endian into 32-bit
// words. After the last data word a latency word (the RUN-cycle count up to
// the final sample) is emitted with m_last. The result byte count is then
// reported to the control logic.
//
// Parameters
//   DATA_WIDTH_OUT  sample width: 8, 16 or 32
//   MAX_WORDS_OUT   max data words per run (latency word excluded)
//
// Ports
//   clk, reset_n               clock, async active-low reset
//   start                      one-cycle pulse, begins a run from IDLE/DONE
//   s_data/s_valid/s_last      sample stream in
//   s_ready                    sample accepted this cycle
//   m_data/m_valid/m_last      packed word stream out (m_last = latency word)
//   m_ready                    write master accepts m_data
//   num_bytes_out              result bytes in the current/last run
//   num_bytes_out_valid        num_bytes_out is final
//   busy                       run in progress (RUN, FLUSH or LAT)
//   overflow                   sticky: samples dropped past MAX_WORDS_OUT
// ---------------------------------------------------------------------------
module task_result_packer #(
    parameter int DATA_WIDTH_OUT = 8,
    parameter int MAX_WORDS_OUT  = 2048
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [DATA_WIDTH_OUT-1:0] s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [31:0]               m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic [31:0]               num_bytes_out,
    output logic                      num_bytes_out_valid,
    output logic                      busy,
    output logic                      overflow
);

    localparam int N      = 32 / DATA_WIDTH_OUT;        // samples per word
    localparam int BPS    = DATA_WIDTH_OUT / 8;         // bytes per sample
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int WCNT_W = $clog2(MAX_WORDS_OUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        LAT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [31:0]         pack_q;        // word being assembled (or a complete word waiting)
    logic                pack_full_q;   // pack_q holds a complete word not yet in the output reg
    logic [LANE_W-1:0]   lane_q;
    logic [WCNT_W-1:0]   words_q;       // data words completed this run
    logic [31:0]         lat_q;
    logic [31:0]         bytes_q;
    logic                nbv_q;
    logic                ovf_q;
    logic [31:0]         m_data_q;
    logic                m_valid_q;
    logic                m_last_q;

    logic [31:0]         word_d;
    logic                word_done;
    logic                discard;
    logic                out_free;
    logic                accept;

    // Merge the incoming sample into its lane. Starting a new word clears the
    // other lanes so a partial final word carries zeros in its upper lanes.
    always_comb begin
        word_d = (lane_q == '0) ? 32'd0 : pack_q;
        word_d[lane_q*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = s_data;
    end

    assign word_done = (lane_q == LANE_W'(N - 1));
    assign discard   = (words_q == WCNT_W'(MAX_WORDS_OUT));
    // Output register can take a new word when empty or draining this cycle.
    assign out_free  = !m_valid_q || m_ready;
    // Stall only when both registers hold a word and the output is not draining.
    assign s_ready   = (state_q == RUN) && !(pack_full_q && m_valid_q && !m_ready);
    assign accept    = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pack_q      <= '0;
            pack_full_q <= 1'b0;
            lane_q      <= '0;
            words_q     <= '0;
            lat_q       <= '0;
            bytes_q     <= '0;
            nbv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            // Drain by default; any load below overrides this.
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        pack_full_q <= 1'b0;
                        lane_q      <= '0;
                        words_q     <= '0;
                        lat_q       <= '0;
                        bytes_q     <= '0;
                        nbv_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end

                RUN: begin
                    if (lat_q != 32'hFFFF_FFFF)
                        lat_q <= lat_q + 32'd1;

                    // Waiting complete word moves out first; pack_q is then
                    // free to take the new sample on the same edge.
                    if (pack_full_q && out_free) begin
                        m_data_q    <= pack_q;
                        m_valid_q   <= 1'b1;
                        m_last_q    <= 1'b0;
                        pack_full_q <= 1'b0;
                    end

                    if (accept) begin
                        if (discard) begin
                            ovf_q <= 1'b1;
                        end else begin
                            pack_q  <= word_d;
                            bytes_q <= bytes_q + 32'(BPS);
                            lane_q  <= word_done ? '0 : lane_q + LANE_W'(1);
                            if (word_done) begin
                                words_q <= words_q + WCNT_W'(1);
                                // Straight to the output register when possible
                                // so full rate has no bubble at word boundaries.
                                if (out_free && !pack_full_q) begin
                                    m_data_q  <= word_d;
                                    m_valid_q <= 1'b1;
                                    m_last_q  <= 1'b0;
                                end else begin
                                    pack_full_q <= 1'b1;
                                end
                            end
                        end
                        // Discard only happens on a word boundary, so there is
                        // never a partial word to flush in that case.
                        if (s_last)
                            state_q <= (discard || word_done) ? LAT : FLUSH;
                    end
                end

                FLUSH: begin
                    // The partial word is alone in pack_q here: any complete
                    // word left the pack register when the last sample landed.
                    if (out_free) begin
                        m_data_q  <= pack_q;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        state_q   <= LAT;
                    end
                end

                LAT: begin
                    if (m_valid_q && m_last_q) begin
                        if (m_ready) begin
                            state_q <= DONE;
                            nbv_q   <= 1'b1;
                        end
                    end else if (pack_full_q) begin
                        if (out_free) begin
                            m_data_q    <= pack_q;
                            m_valid_q   <= 1'b1;
                            m_last_q    <= 1'b0;
                            pack_full_q <= 1'b0;
                        end
                    end else if (out_free) begin
                        m_data_q  <= lat_q;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_data              = m_data_q;
    assign m_valid             = m_valid_q;
    assign m_last              = m_last_q;
    assign num_bytes_out       = bytes_q;
    assign num_bytes_out_valid = nbv_q;
    assign busy                = (state_q == RUN) || (state_q == FLUSH) || (state_q == LAT);
    assign overflow            = ovf_q;

endmodule

// File: tb/tb_task_result_packer.sv
// Bench for task_result_packer: three instances (8-bit, 16-bit, 32-bit with
// MAX_WORDS_OUT=2). Expected words go into a scoreboard queue when a run is
// issued; a negedge monitor pops and compares on every output handshake.
module tb_task_result_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  start, s_valid, s_last, s_ready, m_valid, m_last, m_ready;
    logic [2:0]  nbv, busy, ovf;
    logic [31:0] sd  [3];
    logic [31:0] md  [3];
    logic [31:0] nbo [3];

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_q[$];      // {unit[1:0], last, data}
    logic [34:0] e;
    logic [2:0]  hold_v = '0;
    logic [31:0] hold_d [3];

    always #5 clk = ~clk;

    task_result_packer #(.DATA_WIDTH_OUT(8), .MAX_WORDS_OUT(2048)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]),
        .s_data(sd[0][7:0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
        .m_data(md[0]), .m_valid(m_valid[0]), .m_last(m_last[0]), .m_ready(m_ready[0]),
        .num_bytes_out(nbo[0]), .num_bytes_out_valid(nbv[0]), .busy(busy[0]), .overflow(ovf[0]));

    task_result_packer #(.DATA_WIDTH_OUT(16), .MAX_WORDS_OUT(2048)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]),
        .s_data(sd[1][15:0]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
        .m_data(md[1]), .m_valid(m_valid[1]), .m_last(m_last[1]), .m_ready(m_ready[1]),
        .num_bytes_out(nbo[1]), .num_bytes_out_valid(nbv[1]), .busy(busy[1]), .overflow(ovf[1]));

    task_result_packer #(.DATA_WIDTH_OUT(32), .MAX_WORDS_OUT(2)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start[2]),
        .s_data(sd[2]), .s_valid(s_valid[2]), .s_last(s_last[2]), .s_ready(s_ready[2]),
        .m_data(md[2]), .m_valid(m_valid[2]), .m_last(m_last[2]), .m_ready(m_ready[2]),
        .num_bytes_out(nbo[2]), .num_bytes_out_valid(nbv[2]), .busy(busy[2]), .overflow(ovf[2]));

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input int u, input logic l, input logic [31:0] d);
        exp_q.push_back({u[1:0], l, d});
    endfunction

    // Monitor: scoreboard pops plus stability of a word held under backpressure.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (hold_v[u])
                check("held word stable", 64'({m_valid[u], md[u]}), 64'({1'b1, hold_d[u]}));
            if (reset_n && m_valid[u] && m_ready[u]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected word: unit%0d got=%0h exp=none", u, md[u]);
                end else begin
                    e = exp_q.pop_front();
                    check("out word {unit,last,data}", 64'({u[1:0], m_last[u], md[u]}), 64'(e));
                end
            end
            hold_v[u] = reset_n && m_valid[u] && !m_ready[u];
            hold_d[u] = md[u];
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_start(input int u, input bit chk);
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        if (chk) begin
            check("busy after start", 64'(busy[u]), 64'd1);
            check("s_ready after start", 64'(s_ready[u]), 64'd1);
        end
    endtask

    task automatic put(input int u, input logic [31:0] d, input logic l);
        int t = 0;
        sd[u] = d; s_valid[u] = 1'b1; s_last[u] = l;
        forever begin
            @(negedge clk);
            if (s_ready[u]) break;
            t++;
            if (t > 200) begin
                total++; bad++;
                $display("FAIL s_ready timeout: unit%0d got=0 exp=1", u);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid[u] = 1'b0; s_last[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int t = 0;
        while (!nbv[u] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("num_bytes_out_valid seen", 64'(nbv[u]), 64'd1);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        check("busy after done", 64'(busy[u]), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = '0; s_valid = '0; s_last = '0; m_ready = '1;
        for (int u = 0; u < 3; u++) sd[u] = '0;

        // Reset values
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("reset s_ready", 64'(s_ready[u]), 64'd0);
            check("reset m_valid", 64'(m_valid[u]), 64'd0);
            check("reset m_last",  64'(m_last[u]),  64'd0);
            check("reset m_data",  64'(md[u]),      64'd0);
            check("reset nbo",     64'(nbo[u]),     64'd0);
            check("reset nbv",     64'(nbv[u]),     64'd0);
            check("reset busy",    64'(busy[u]),    64'd0);
            check("reset overflow",64'(ovf[u]),     64'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 8-bit, five samples, partial final word
        push(0, 1'b0, 32'h44332211);
        push(0, 1'b0, 32'h00000055);
        push(0, 1'b1, 32'd5);
        do_start(0, 1'b1);
        put(0, 32'h11, 1'b0); put(0, 32'h22, 1'b0); put(0, 32'h33, 1'b0);
        put(0, 32'h44, 1'b0); put(0, 32'h55, 1'b1);
        wait_done(0);
        check("t1 num_bytes", 64'(nbo[0]), 64'd5);
        check("t1 overflow",  64'(ovf[0]),  64'd0);

        // 16-bit, four samples, exact words
        push(1, 1'b0, 32'hBBBBAAAA);
        push(1, 1'b0, 32'hDDDDCCCC);
        push(1, 1'b1, 32'd4);
        do_start(1, 1'b1);
        put(1, 32'hAAAA, 1'b0); put(1, 32'hBBBB, 1'b0);
        put(1, 32'hCCCC, 1'b0); put(1, 32'hDDDD, 1'b1);
        wait_done(1);
        check("t2 num_bytes", 64'(nbo[1]), 64'd8);

        // Backpressure: m_ready low for the first 10 RUN cycles, 12 samples.
        // Samples land on RUN edges 1-8 and 11-14, so latency = 14.
        push(0, 1'b0, 32'h04030201);
        push(0, 1'b0, 32'h08070605);
        push(0, 1'b0, 32'h0C0B0A09);
        push(0, 1'b1, 32'd14);
        m_ready[0] = 1'b0;
        do_start(0, 1'b1);
        fork
            begin
                for (int i = 1; i <= 12; i++) put(0, 32'(i), (i == 12));
            end
            begin
                repeat (9) @(posedge clk);
                @(negedge clk);
                check("t3 s_ready stalled", 64'(s_ready[0]), 64'd0);
                check("t3 held m_valid",    64'(m_valid[0]), 64'd1);
                check("t3 held m_data",     64'(md[0]),      64'h04030201);
                @(posedge clk); #1;
                m_ready[0] = 1'b1;
            end
        join
        wait_done(0);
        check("t3 num_bytes", 64'(nbo[0]), 64'd12);

        // Overflow: 32-bit, MAX_WORDS_OUT=2, three samples
        push(2, 1'b0, 32'h11111111);
        push(2, 1'b0, 32'h22222222);
        push(2, 1'b1, 32'd3);
        do_start(2, 1'b1);
        put(2, 32'h11111111, 1'b0); put(2, 32'h22222222, 1'b0); put(2, 32'h33333333, 1'b1);
        wait_done(2);
        check("t4 overflow",  64'(ovf[2]), 64'd1);
        check("t4 num_bytes", 64'(nbo[2]), 64'd8);
        // Next run clears overflow
        push(2, 1'b0, 32'hDEADBEEF);
        push(2, 1'b1, 32'd1);
        do_start(2, 1'b1);
        put(2, 32'hDEADBEEF, 1'b1);
        wait_done(2);
        check("t4b overflow",  64'(ovf[2]), 64'd0);
        check("t4b num_bytes", 64'(nbo[2]), 64'd4);

        // Reset mid-run after 3 samples: nothing may come out
        do_start(0, 1'b1);
        put(0, 32'hA1, 1'b0); put(0, 32'hA2, 1'b0); put(0, 32'hA3, 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("t5 busy after reset",    64'(busy[0]),    64'd0);
        check("t5 m_valid after reset", 64'(m_valid[0]), 64'd0);
        check("t5 s_ready after reset", 64'(s_ready[0]), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        push(0, 1'b0, 32'hB4B3B2B1);
        push(0, 1'b1, 32'd4);
        do_start(0, 1'b1);
        put(0, 32'hB1, 1'b0); put(0, 32'hB2, 1'b0); put(0, 32'hB3, 1'b0); put(0, 32'hB4, 1'b1);
        wait_done(0);
        check("t5 num_bytes", 64'(nbo[0]), 64'd4);

        // start during RUN is ignored; the idle RUN cycle it spans still counts
        push(1, 1'b0, 32'h22221111);
        push(1, 1'b0, 32'h00003333);
        push(1, 1'b1, 32'd4);
        do_start(1, 1'b1);
        put(1, 32'h1111, 1'b0);
        do_start(1, 1'b0);
        put(1, 32'h2222, 1'b0); put(1, 32'h3333, 1'b1);
        wait_done(1);
        check("t6 num_bytes", 64'(nbo[1]), 64'd6);
        // Restart after DONE drops num_bytes_out_valid on the next cycle
        push(1, 1'b0, 32'h00004444);
        push(1, 1'b1, 32'd1);
        do_start(1, 1'b1);
        check("t6 nbv after restart", 64'(nbv[1]), 64'd0);
        check("t6 nbo after restart", 64'(nbo[1]), 64'd0);
        put(1, 32'h4444, 1'b1);
        wait_done(1);
        check("t6b num_bytes", 64'(nbo[1]), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task_result_packer.md
# task_result_packer

Output-side stage between a task core and the shared-memory write master. It accepts the task's result samples (DATA_WIDTH_OUT bits each) on a valid/ready stream and packs them little-endian into 32-bit words. It then appends a task-latency word and reports the result byte count to the control logic. The write master stores the emitted words consecutively from TASK_OUT_OFFSET, so software finds data words, then the latency word.

## Interface
- DATA_WIDTH_OUT, 8: result sample width; legal values are 8, 16 and 32.
- MAX_WORDS_OUT, 2048: maximum number of 32-bit data words per run, excluding the latency word.
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run.
- s_data  in  DATA_WIDTH_OUT  result sample from the task core.
- s_valid  in  1  sample valid.
- s_last  in  1  marks the final sample of the run; qualified by s_valid.
- s_ready  out  1  packer accepts the sample this cycle.
- m_data  out  32  packed word to the write master.
- m_valid  out  1  m_data valid.
- m_last  out  1  high only with the latency word.
- m_ready  in  1  write master accepts m_data.
- num_bytes_out  out  32  result bytes in the run, excluding the latency word.
- num_bytes_out_valid  out  1  num_bytes_out is final.
- busy  out  1  a run is in progress (state is not IDLE or DONE).
- overflow  out  1  sticky flag: a sample arrived beyond MAX_WORDS_OUT words.

## Operation
- N = 32/DATA_WIDTH_OUT samples per word. Sample k of the run goes to word k/N, lane bits [DATA_WIDTH_OUT*(k%N) +: DATA_WIDTH_OUT].
- num_bytes_out = sample_count*DATA_WIDTH_OUT/8, counted modulo 2^32.
- In a partial final word, unused upper lanes are 0.
- States:
  - IDLE: waiting for start.
  - RUN: accepting samples.
  - FLUSH: pushing the partial final word.
  - LAT: emitting the latency word.
  - DONE: waiting for the next start.
- Transitions:
  - IDLE or DONE to RUN on start. Entering RUN clears the sample count, lane index, latency counter, overflow, and num_bytes_out_valid.
  - RUN to FLUSH when a sample with s_last is accepted and it does not complete a word.
  - RUN to LAT when a sample with s_last is accepted and it completes a word.
  - FLUSH to LAT when the partial word is loaded into the output register.
  - LAT to DONE on the m_valid&&m_ready handshake of the latency word.
- Latency counter:
  - Starts at 0 on the cycle start is sampled.
  - Increments every cycle in RUN and saturates at 0xFFFFFFFF.
  - Freezes on the cycle the s_last sample is accepted.
  - The latency word equals the number of RUN cycles up to and including that acceptance.
- Buffering is one pack register plus one output register (m_data/m_valid/m_last).
  - A completed word moves to the output register when it is empty or draining (m_ready=1).
  - s_ready = (state==RUN) && !(pack register complete && output register held).
- Overflow: once MAX_WORDS_OUT words have been emitted, further samples are still accepted but discarded and not counted, and overflow is set. s_last still ends the run normally.
- start while busy is ignored.
- s_valid outside RUN is not accepted (s_ready=0).
- A zero-sample run is impossible: the first accepted sample may itself carry s_last.

## Timing
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, num_bytes_out=0, num_bytes_out_valid=0, busy=0, overflow=0; state IDLE.
- Reset asserted mid-run aborts the run immediately. No partial word or latency word is emitted afterwards.
- start sampled at edge T: busy=1 and s_ready=1 from T+1.
- A word completes with the sample accepted at edge T: m_valid=1 from T+1. m_valid holds, with m_data stable, until m_ready.
- FLUSH takes 1 cycle when the output register is free.
- The latency word is presented on the cycle after the last data word leaves the output register, or is loaded together with it if the register drains that cycle.
- num_bytes_out_valid rises on the edge that completes the latency-word handshake. It and num_bytes_out hold until the next accepted start.
- At full rate (m_ready=1, s_valid=1): 1 sample per cycle, with no bubbles at word boundaries.

## Test plan
- DATA_WIDTH_OUT=8, samples 0x11,0x22,0x33,0x44,0x55 (last), m_ready=1 -> m_data 0x44332211, then 0x00000055, then the latency word 0x00000005 with m_last; num_bytes_out=5, then num_bytes_out_valid=1.
- DATA_WIDTH_OUT=16, 4 samples 0xAAAA,0xBBBB,0xCCCC,0xDDDD (last) -> words 0xBBBBAAAA, 0xDDDDCCCC, then the latency word; no FLUSH cycle; num_bytes_out=8.
- Backpressure: m_ready low for 10 cycles while 8-bit samples stream -> s_ready drops after 8 samples are buffered; m_data stays stable; no sample is lost or duplicated; the latency word includes the stall cycles.
- MAX_WORDS_OUT=2, DATA_WIDTH_OUT=32, 3 samples (last on the third) -> 2 data words, overflow=1, num_bytes_out=8, latency word still emitted.
- reset_n pulsed low in RUN after 3 samples, then a new start with 4 samples -> no output from the aborted run; the new run reports num_bytes_out=4 (8-bit).
- start pulsed during RUN -> ignored; the run completes with unchanged counts. A second start after DONE -> num_bytes_out_valid falls the next cycle.
